bandai_mapper_v2: RTL

Parametrised successor to the cartridge mapper. It implements a configurable-length addressed unlock sequence, a configurable serial bitstream on SO, and NBANK synchronously written bank registers with readback. Sequence progress can optionally be reset on a bad address or on a timeout. It sits between the cartridge edge (CEn/SSn/WEn/OEn/ADDR/DQ) and the ROM/RAM banking logic, which consumes BANK_OUT.

---
 rtl/bandai_mapper_v2_if.sv | 30 +++
 rtl/bandai_mapper_v2.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bandai_mapper_v2_if.sv
// Cartridge-edge bus between the host side and the bandai_mapper_v2 block.
// The mapper uses the slave modport; the driver of the cartridge pins uses master.
interface bandai_mapper_v2_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NBANK  = 4
);
  logic                    cen;
  logic                    ssn;
  logic                    wen;
  logic                    oen;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       dq_i;
  logic [DATA_W-1:0]       dq_o;
  logic                    dq_oe;
  logic                    so;
  logic                    locked;
  logic                    busy;
  logic [NBANK*DATA_W-1:0] bank_out;

  modport master (
    output cen, ssn, wen, oen, addr, dq_i,
    input  dq_o, dq_oe, so, locked, busy, bank_out
  );

  modport slave (
    input  cen, ssn, wen, oen, addr, dq_i,
    output dq_o, dq_oe, so, locked, busy, bank_out
  );
endinterface

// File: rtl/bandai_mapper_v2.sv
// Parametrised cartridge mapper: addressed unlock sequence, serial bitstream on SO,
// and NBANK bank registers that can be written and read back once unlocked.
module bandai_mapper_v2 #(
  parameter int                        DATA_W    = 8,
  parameter int                        ADDR_W    = 8,
  parameter int                        NBANK     = 4,
  parameter logic [ADDR_W-1:0]         BANK_BASE = 8'hC0,
  parameter logic [DATA_W-1:0]         BANK_RST  = 8'hFF,
  parameter int                        SEQ_LEN   = 2,
  parameter logic [SEQ_LEN*ADDR_W-1:0] SEQ       = 16'h5AA5,
  parameter int                        BS_W      = 18,
  parameter logic [BS_W-1:0]           BS        = 18'h05140,
  parameter bit                        STRICT    = 1'b0,
  parameter int                        TIMEOUT   = 0
) (
  input logic               clk,
  input logic               rst,
  bandai_mapper_v2_if.slave bus
);

  localparam int KW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW = $clog2(BS_W + 1);
  localparam int IW = $clog2(NBANK);

  typedef enum logic {ST_SEQ, ST_OPEN} state_t;

  state_t                         state;
  state_t                         state_n;
  logic [KW-1:0]                  k;
  logic [KW-1:0]                  k_n;
  logic [TW-1:0]                  timer;
  logic [TW-1:0]                  timer_n;
  logic                           load;
  logic [SEQ_LEN-1:0][ADDR_W-1:0] seq_arr;
  logic [ADDR_W-1:0]              elem_cur;
  logic [ADDR_W-1:0]              elem_prev;
  logic [BS_W-1:0]                sr;
  logic [CW-1:0]                  cnt;
  logic [NBANK-1:0][DATA_W-1:0]   bank;
  logic                           sel;
  logic                           hit;
  logic [IW-1:0]                  idx;
  logic                           locked;
  logic                           wr;
  logic                           rd;

  // Element 0 lives in the MSBs, so element k sits at packed index SEQ_LEN-1-k.
  assign seq_arr   = SEQ;
  assign elem_cur  = seq_arr[SEQ_LEN - 1 - int'(k)];
  assign elem_prev = seq_arr[(SEQ_LEN - int'(k)) % SEQ_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SEQ;
      k     <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      timer <= timer_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    timer_n = timer;
    load    = 1'b0;
    if (state == ST_SEQ) begin
      if (bus.addr == elem_cur) begin
        timer_n = '0;
        if (k == KW'(SEQ_LEN - 1)) begin
          state_n = ST_OPEN;
          k_n     = '0;
          load    = 1'b1;
        end else begin
          k_n = k + 1'b1;
        end
      end else begin
        if (TIMEOUT > 0 && k != '0) begin
          if (timer + 1'b1 == TW'(TIMEOUT)) begin
            k_n     = '0;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        // A held address (the element just matched) is tolerated even in strict mode.
        if (STRICT && k != '0 && bus.addr != elem_prev) begin
          k_n     = '0;
          timer_n = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '1;
      cnt  <= '0;
      bank <= {NBANK{BANK_RST}};
    end else begin
      if (load) begin
        sr  <= BS;
        cnt <= CW'(BS_W);
      end else begin
        sr <= {1'b1, sr[BS_W-1:1]};
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (wr) bank[idx] <= bus.dq_i;
    end
  end

  // The bank window is NBANK-aligned, so an upper-bit compare is the range check.
  always_comb begin
    sel          = ~(bus.ssn & bus.cen);
    hit          = sel && (bus.addr[ADDR_W-1:IW] == BANK_BASE[ADDR_W-1:IW]);
    idx          = bus.addr[IW-1:0];
    locked       = (state != ST_OPEN);
    wr           = hit & ~bus.wen & bus.oen & ~locked;
    rd           = hit & ~bus.oen & bus.wen & ~locked;
    bus.locked   = locked;
    bus.so       = sr[0];
    bus.busy     = (cnt != '0);
    bus.dq_oe    = rd;
    bus.dq_o     = rd ? bank[idx] : '0;
    bus.bank_out = bank;
  end

endmodule
